// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Optional macro WB_ARB_PRIO0_EN: source 0 gets absolute priority, bounded by STARVE_LIMIT.
module wb_port_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hold_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         we_o,
    output logic [ADDR_W-1:0]            waddr_o,
    output logic [DATA_W-1:0]            wdata_o,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    // Returns {found, index} of the first set bit of mask scanning upward from start with wrap.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                              input logic [ID_W-1:0]    start);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = {(ID_W+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(start) + k) % NUM_REQ);
            res = mask[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W:0]     pick_s;
    logic              gnt_valid_s;
    logic [ID_W-1:0]   gnt_idx_s;
    logic [ID_W-1:0]   gnt_next_s;
    logic [ADDR_W-1:0] gnt_addr_s;
    logic [DATA_W-1:0] gnt_data_s;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ID_W-1:0]   gid_q;

`ifdef WB_ARB_PRIO0_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] others_s;
    logic               starve_s;

    assign others_s = req_valid_i & ~{{(NUM_REQ-1){1'b0}}, 1'b1};
    assign starve_s = (cnt_q >= CNT_W'(STARVE_LIMIT)) && (|others_s);
`endif

    // Grant selection: nothing is granted while held or in reset.
    always_comb begin
        pick_s = {(ID_W+1){1'b0}};
        if (!hold_i && !rst) begin
`ifdef WB_ARB_PRIO0_EN
            if (starve_s) begin
                pick_s = rr_pick(others_s, ptr_q);
            end else if (req_valid_i[0]) begin
                pick_s = {1'b1, {ID_W{1'b0}}};
            end else begin
                pick_s = rr_pick(req_valid_i, ptr_q);
            end
`else
            pick_s = rr_pick(req_valid_i, ptr_q);
`endif
        end else begin
            pick_s = {(ID_W+1){1'b0}};
        end
    end

    assign gnt_valid_s = pick_s[ID_W];
    assign gnt_idx_s   = pick_s[ID_W-1:0];
    assign gnt_next_s  = (gnt_idx_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : gnt_idx_s + ID_W'(1);
    assign gnt_addr_s  = req_addr_i[gnt_idx_s*ADDR_W +: ADDR_W];
    assign gnt_data_s  = req_data_i[gnt_idx_s*DATA_W +: DATA_W];
    assign req_ready_o = gnt_valid_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_s)
                                     : {NUM_REQ{1'b0}};

    // Pointer (and starvation counter) next state.
    always_comb begin
        ptr_d = ptr_q;
`ifdef WB_ARB_PRIO0_EN
        cnt_d = cnt_q;
        if (gnt_valid_s && (gnt_idx_s != {ID_W{1'b0}})) begin
            ptr_d = gnt_next_s;
            cnt_d = {CNT_W{1'b0}};
        end else if (gnt_valid_s && (|others_s)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
`else
        if (gnt_valid_s) begin
            ptr_d = gnt_next_s;
        end else begin
            ptr_d = ptr_q;
        end
`endif
    end

    // Arbitration state and registered write port; x0 writes leave address/data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= {ID_W{1'b0}};
            we_q    <= 1'b0;
            waddr_q <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            gid_q   <= {ID_W{1'b0}};
`ifdef WB_ARB_PRIO0_EN
            cnt_q   <= {CNT_W{1'b0}};
`endif
        end else begin
            ptr_q <= ptr_d;
`ifdef WB_ARB_PRIO0_EN
            cnt_q <= cnt_d;
`endif
            if (gnt_valid_s && (gnt_addr_s != {ADDR_W{1'b0}})) begin
                we_q    <= 1'b1;
                waddr_q <= gnt_addr_s;
                wdata_q <= gnt_data_s;
                gid_q   <= gnt_idx_s;
            end else begin
                we_q    <= 1'b0;
            end
        end
    end

    assign we_o       = we_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign grant_id_o = gid_q;

endmodule
